hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipeline. It generalises per-operand forwarding to NUM_SRC sources and adds:
- load-use stall/bubble generation
- branch flush
- a freeze FSM for variable-latency data memory, with a hold buffer that keeps the retired WB result forwardable while the pipeline is frozen
- a freeze watchdog

It sits beside ID/EX control and drives the operand-select muxes in EX and the stall/flush enables of the pipeline registers.

Parameters:
NUM_SRC, 2, number of source operands per instruction (2 or 3).
REG_ADDR_W, 5, register index width.
MAX_FREEZE, 255, freeze cycles before the watchdog fires (must be ≥1).

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  reset; asynchronous, active-low.
i_id_rs  in  NUM_SRC*REG_ADDR_W  source indices of the ID instruction; source i at [i*REG_ADDR_W +: REG_ADDR_W].
i_id_rs_used  in  NUM_SRC  per-source "operand actually read" flag.
i_ex_rs  in  NUM_SRC*REG_ADDR_W  source indices held in ID/EX.
i_ex_rd  in  REG_ADDR_W  destination held in ID/EX.
i_ex_mem_read  in  1  ID/EX instruction is a load.
i_ex_branch_taken  in  1  EX resolved a taken branch or jump.
i_mem_rd  in  REG_ADDR_W  EX/MEM destination.
i_mem_reg_write  in  1  EX/MEM writes the register file.
i_mem_mem_read  in  1  EX/MEM instruction is a load.
i_wb_rd  in  REG_ADDR_W  MEM/WB destination.
i_wb_reg_write  in  1  MEM/WB writes the register file.
i_dmem_busy  in  1  data memory has not completed the current access.
o_forward  out  2*NUM_SRC  per-source select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB data, 11 hold buffer.
o_pc_stall  out  1  hold the PC.
o_ifid_stall  out  1  hold IF/ID.
o_ifid_flush  out  1  load a bubble into IF/ID.
o_idex_flush  out  1  load a bubble into ID/EX.
o_freeze  out  1  hold PC, IF/ID, ID/EX and EX/MEM; MEM/WB loads a bubble.
o_hold_capture  out  1  datapath latches the MEM/WB write data into the hold register at this edge.
o_timeout  out  1  sticky watchdog flag.
o_perf_loaduse  out  32  load-use bubble count (HAZARD_PERF_EN).
o_perf_freeze  out  32  freeze cycle count (HAZARD_PERF_EN).

Behaviour:
- Reset (async assert, sync-safe release):
  - state=RUN, hold_valid=0, hold_rd=0, freeze_cnt=0, o_timeout=0, perf counters=0.
  - All combinational outputs settle to 0 with inputs idle.
- Forwarding per source i, combinational, priority in this order:
  - 01 when i_mem_reg_write & !i_mem_mem_read & i_mem_rd≠0 & i_mem_rd==ex_rs[i].
  - Else 10 when i_wb_reg_write & i_wb_rd≠0 & i_wb_rd==ex_rs[i].
  - Else 11 when hold_valid & hold_rd==ex_rs[i]; hold_rd≠0 is guaranteed by capture.
  - Else 00.
- Load-use detection: i_ex_mem_read & i_ex_rd≠0 & OR_i(i_id_rs_used[i] & id_rs[i]==i_ex_rd).
- Control priority, evaluated each cycle:
  - o_freeze=i_dmem_busy. While frozen, all other stall/flush outputs are 0.
  - Otherwise, if i_ex_branch_taken: o_ifid_flush=o_idex_flush=1, no stall. Branch overrides load-use.
  - Otherwise, if load-use: o_pc_stall=o_ifid_stall=o_idex_flush=1. This gives exactly one bubble, because the load advances to MEM next cycle.
- FSM states and transitions:
  - RUN→FREEZE on i_dmem_busy. o_hold_capture=1 in that cycle only.
  - At that edge: hold_rd←i_wb_rd; hold_valid←i_wb_reg_write & i_wb_rd≠0.
  - FREEZE→FREEZE while busy; no further capture, since WB carries bubbles.
  - FREEZE→RUN when busy drops. hold_valid stays 1 during that release cycle and clears at its edge.
  - A new busy in the cycle right after release re-enters FREEZE with a fresh capture.
- Watchdog:
  - freeze_cnt increments each FREEZE cycle, saturating at MAX_FREEZE.
  - Reaching MAX_FREEZE sets o_timeout, which holds until reset.
  - freeze_cnt clears on return to RUN.
- Reset asserted mid-freeze: returns to RUN immediately; hold and counters cleared.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - o_perf_loaduse increments on each cycle of an effective load-use stall (not masked by freeze or branch).
  - o_perf_freeze increments on each cycle with o_freeze=1.
  - Both are saturating 32-bit counters, cleared only by reset.
- Undefined: counter logic is absent and both ports are tied to 0. All other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e (FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, FWD_HOLD=2'b11)
  - hz_state_e (RUN, FREEZE)
  - default REG_ADDR_W
- Sub-module fwd_select: combinational per-source priority mux, instantiated NUM_SRC times in a generate loop.
- FSM, hold tracking, watchdog and perf counters stay in the top module.

Test Plan:
- EX/MEM rd=5 reg_write, WB rd=5 reg_write, ex_rs0=5 → o_forward[1:0]=01 (MEM wins). Repeat with rd=0 → 00.
- ID/EX load rd=7, id_rs1=7, rs_used[1]=1 → one cycle of pc_stall=ifid_stall=idex_flush=1; next cycle all 0. With rs_used[1]=0 → no stall.
- Load-use plus i_ex_branch_taken in the same cycle → ifid_flush=idex_flush=1, pc_stall=0.
- WB rd=9 reg_write, busy asserted 4 cycles, ex_rs1=9 → hold_capture for 1 cycle; o_forward[3:2]=10 in the first cycle, then 11 through the release cycle, then 00.
- MAX_FREEZE=3, busy held 5 cycles → o_timeout rises after the 3rd freeze cycle and stays 1 after busy drops.
- Reset pulsed during FREEZE → o_freeze follows busy only; hold_valid=0, forward=00 for ex_rs matching the old hold_rd.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the hazard/forwarding controller
package hazard_pkg;
    localparam int HZ_REG_ADDR_W = 5;
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_HOLD = 2'b11
    } fwd_sel_e;
    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } hz_state_e;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority operand-source mux for one EX source register
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] i_ex_rs,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic                  i_mem_mem_read,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_wb_reg_write,
    input  logic                  i_hold_valid,
    input  logic [REG_ADDR_W-1:0] i_hold_rd,
    output fwd_sel_e              o_sel
);
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_hold_hit;
    // Youngest producer wins; a load in EX/MEM has no ALU result to forward yet
    always_comb begin
        w_mem_hit  = i_mem_reg_write && !i_mem_mem_read && i_mem_rd != '0 && i_mem_rd == i_ex_rs;
        w_wb_hit   = i_wb_reg_write && i_wb_rd != '0 && i_wb_rd == i_ex_rs;
        w_hold_hit = i_hold_valid && i_hold_rd == i_ex_rs;
        o_sel      = w_mem_hit ? FWD_MEM : w_wb_hit ? FWD_WB : w_hold_hit ? FWD_HOLD : FWD_NONE;
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: forwarding, load-use stall, branch flush and memory freeze control (optional perf counters: HAZARD_PERF_EN)
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = HZ_REG_ADDR_W,
    parameter int MAX_FREEZE = 255
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    i_id_rs,
    input  logic [NUM_SRC-1:0]               i_id_rs_used,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    i_ex_rs,
    input  logic [REG_ADDR_W-1:0]            i_ex_rd,
    input  logic                             i_ex_mem_read,
    input  logic                             i_ex_branch_taken,
    input  logic [REG_ADDR_W-1:0]            i_mem_rd,
    input  logic                             i_mem_reg_write,
    input  logic                             i_mem_mem_read,
    input  logic [REG_ADDR_W-1:0]            i_wb_rd,
    input  logic                             i_wb_reg_write,
    input  logic                             i_dmem_busy,
    output logic [2*NUM_SRC-1:0]             o_forward,
    output logic                             o_pc_stall,
    output logic                             o_ifid_stall,
    output logic                             o_ifid_flush,
    output logic                             o_idex_flush,
    output logic                             o_freeze,
    output logic                             o_hold_capture,
    output logic                             o_timeout,
    output logic [31:0]                      o_perf_loaduse,
    output logic [31:0]                      o_perf_freeze
);
    localparam int CW = $clog2(MAX_FREEZE + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_FREEZE);

    hz_state_e               r_state;
    hz_state_e               w_state_nxt;
    logic                    r_hold_valid;
    logic [REG_ADDR_W-1:0]   r_hold_rd;
    logic [CW-1:0]           r_freeze_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    r_timeout;
    logic                    w_capture;
    logic                    w_release;
    logic                    w_load_use;
    logic                    w_lu_eff;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_fwd
            fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
                .i_ex_rs        (i_ex_rs[g*REG_ADDR_W +: REG_ADDR_W]),
                .i_mem_rd       (i_mem_rd),
                .i_mem_reg_write(i_mem_reg_write),
                .i_mem_mem_read (i_mem_mem_read),
                .i_wb_rd        (i_wb_rd),
                .i_wb_reg_write (i_wb_reg_write),
                .i_hold_valid   (r_hold_valid),
                .i_hold_rd      (r_hold_rd),
                .o_sel          (o_forward[2*g +: 2])
            );
        end
    endgenerate

    // Load in ID/EX whose destination is read by the instruction in ID
    always_comb begin
        w_load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            w_load_use = w_load_use | (i_id_rs_used[i] && i_id_rs[i*REG_ADDR_W +: REG_ADDR_W] == i_ex_rd);
        w_load_use = w_load_use && i_ex_mem_read && i_ex_rd != '0;
    end

    // Freeze masks everything, then branch flush, then the one-cycle load-use bubble
    always_comb begin
        o_freeze     = i_dmem_busy;
        w_lu_eff     = !i_dmem_busy && !i_ex_branch_taken && w_load_use;
        o_pc_stall   = w_lu_eff;
        o_ifid_stall = w_lu_eff;
        o_ifid_flush = !i_dmem_busy && i_ex_branch_taken;
        o_idex_flush = !i_dmem_busy && (i_ex_branch_taken || w_load_use);
    end

    // Freeze FSM next state: entry captures the retiring WB result, release frees it
    always_comb begin
        w_state_nxt    = i_dmem_busy ? FREEZE : RUN;
        w_capture      = r_state == RUN && i_dmem_busy;
        w_release      = r_state == FREEZE && !i_dmem_busy;
        o_hold_capture = w_capture;
        w_cnt_nxt      = !i_dmem_busy ? '0 : r_freeze_cnt == MAXC ? r_freeze_cnt : r_freeze_cnt + CW'(1);
        o_timeout      = r_timeout;
    end

    // State, hold buffer tag and watchdog registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= RUN;
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_freeze_cnt <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_valid <= w_capture ? (i_wb_reg_write && i_wb_rd != '0) : w_release ? 1'b0 : r_hold_valid;
            r_hold_rd    <= w_capture ? i_wb_rd : r_hold_rd;
            r_freeze_cnt <= w_cnt_nxt;
            r_timeout    <= r_timeout || w_cnt_nxt == MAXC;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_fz;
    // Saturating event counters, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_lu <= '0;
            r_perf_fz <= '0;
        end else begin
            r_perf_lu <= r_perf_lu + {31'd0, w_lu_eff && !(&r_perf_lu)};
            r_perf_fz <= r_perf_fz + {31'd0, i_dmem_busy && !(&r_perf_fz)};
        end
    end
    assign o_perf_loaduse = r_perf_lu;
    assign o_perf_freeze  = r_perf_fz;
`else
    assign o_perf_loaduse = '0;
    assign o_perf_freeze  = '0;
`endif
endmodule
